dpr_host_master: RTL and testbench

Host-side access sequencer driving the 1024x16 single-block dual-port RAM (`dpr_as`) port. Accepts read/write requests on a valid/ready interface and drives the RAM strobes (`blk_sel`, `addr_en`, `wr_en`, `rd_en`, `dout_en`) in the required order. Captures registered read data, checks it against the RAM's `parity_out`, and returns data plus a parity-error flag on a valid/ready response channel. Sits between the system bus adapter and the RAM instance.

---
 rtl/dpr_pkg.sv | 17 +
 rtl/dpr_parity_chk.sv | 15 +
 rtl/dpr_host_master.sv | 136 +++++++++++++
 tb/tb_dpr_host_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpr_pkg.sv
// rtl/dpr_pkg.sv - shared types and widths for the dpr host-side access sequencer
package dpr_pkg;

    localparam int DPR_AW     = 10;
    localparam int DPR_DW     = 16;
    localparam int PERR_CNT_W = 8;
    localparam int LAT_CNT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RSP
    } dpr_state_e;

endpackage

// File: rtl/dpr_parity_chk.sv
// rtl/dpr_parity_chk.sv - even-parity mismatch check on RAM read data
module dpr_parity_chk
    import dpr_pkg::*;
#(
    parameter int DW = DPR_DW
) (
    input  logic [DW-1:0] data,
    input  logic          parity,
    output logic          mismatch
);

    // Even parity: the stored bit must equal the XOR of the data bits.
    assign mismatch = (parity != (^data));

endmodule

// File: rtl/dpr_host_master.sv
// rtl/dpr_host_master.sv - request/response sequencer driving the dual-port RAM strobes
module dpr_host_master
    import dpr_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int AW     = DPR_AW,
    parameter int DW     = DPR_DW
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [AW-1:0]         req_addr,
    input  logic [DW-1:0]         req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_perr,
    output logic [PERR_CNT_W-1:0] perr_cnt,
    output logic [DW-1:0]         mem_din,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic                  mem_blk_sel,
    output logic                  mem_addr_en,
    output logic                  mem_dout_en,
    input  logic [DW-1:0]         mem_dout,
    input  logic                  mem_parity_out
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);
    localparam logic [PERR_CNT_W-1:0] PERR_MAX = '1;

    dpr_state_e             state_q, state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q;
    logic [AW-1:0]          addr_q;
    logic [DW-1:0]          din_q;
    logic                   accept;
    logic                   sample;
    logic                   par_mismatch;

    dpr_parity_chk #(.DW(DW)) u_parity_chk (
        .data     (mem_dout),
        .parity   (mem_parity_out),
        .mismatch (par_mismatch)
    );

    // The address/data registers only load on accept, so the RAM pins
    // change only when a new access is launched.
    assign mem_addr = addr_q;
    assign mem_din  = din_q;

    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_blk_sel = 1'b0;
        mem_addr_en = 1'b0;
        mem_dout_en = 1'b0;
        accept      = 1'b0;
        sample      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = ~rst;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_wr ? ST_WRITE : ST_RD_ADDR;
                end
            end
            ST_WRITE: begin
                mem_blk_sel = 1'b1;
                mem_addr_en = 1'b1;
                mem_wr_en   = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_RD_ADDR: begin
                mem_blk_sel = 1'b1;
                mem_addr_en = 1'b1;
                mem_rd_en   = 1'b1;
                state_d     = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                mem_blk_sel = 1'b1;
                mem_rd_en   = 1'b1;
                mem_dout_en = 1'b1;
                if (lat_cnt_q == '0) begin
                    sample  = 1'b1;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
            perr_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= req_addr;
                if (req_wr) begin
                    din_q <= req_wdata;
                end
            end
            if (state_q == ST_RD_ADDR) begin
                lat_cnt_q <= LAT_LOAD;
            end else if (state_q == ST_RD_WAIT && lat_cnt_q != '0) begin
                lat_cnt_q <= lat_cnt_q - 1'b1;
            end
            if (sample) begin
                rsp_rdata <= mem_dout;
                rsp_perr  <= par_mismatch;
                if (par_mismatch && perr_cnt != PERR_MAX) begin
                    perr_cnt <= perr_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dpr_host_master.sv
// tb/tb_dpr_host_master.sv - scoreboard bench for dpr_host_master with a behavioural RAM
module tb_dpr_host_master;

    localparam int RD_LAT = 2;

    typedef struct {
        logic [15:0] data;
        logic        perr;
    } exp_t;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_perr;
    logic [7:0]  perr_cnt;
    logic [15:0] mem_din;
    logic [9:0]  mem_addr;
    logic        mem_wr_en, mem_rd_en, mem_blk_sel, mem_addr_en, mem_dout_en;
    logic [15:0] mem_dout;
    logic        mem_parity_out;

    logic [15:0] ram [0:1023];
    logic [9:0]  ram_raddr;
    logic        ram_init;
    logic        inject;
    logic [15:0] shadow [0:1023];
    exp_t        sb [$];
    int          passed = 0;
    int          total  = 0;

    always #5 clk1 = ~clk1;

    dpr_host_master #(.RD_LAT(RD_LAT), .AW(10), .DW(16)) dut (
        .clk1           (clk1),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_perr       (rsp_perr),
        .perr_cnt       (perr_cnt),
        .mem_din        (mem_din),
        .mem_addr       (mem_addr),
        .mem_wr_en      (mem_wr_en),
        .mem_rd_en      (mem_rd_en),
        .mem_blk_sel    (mem_blk_sel),
        .mem_addr_en    (mem_addr_en),
        .mem_dout_en    (mem_dout_en),
        .mem_dout       (mem_dout),
        .mem_parity_out (mem_parity_out)
    );

    // RAM model: address captured on the RD_ADDR edge, data registered on
    // dout_en edges, parity generated from the stored word (optionally inverted).
    always @(posedge clk1) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            mem_dout       <= '0;
            mem_parity_out <= 1'b0;
            ram_raddr      <= '0;
        end else begin
            if (mem_blk_sel && mem_addr_en && mem_wr_en) ram[mem_addr] <= mem_din;
            if (mem_blk_sel && mem_addr_en && mem_rd_en) ram_raddr <= mem_addr;
            if (mem_blk_sel && mem_dout_en && !mem_addr_en) begin
                mem_dout       <= ram[ram_raddr];
                mem_parity_out <= (^ram[ram_raddr]) ^ inject;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        total++;
        $error("FAIL %s: timed out", tag);
    endtask

    always @(negedge clk1) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                timeout("rsp_unexpected");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, e.data});
                check("rsp_perr", {31'h0, rsp_perr}, {31'h0, e.perr});
            end
        end
    end

    task automatic do_req(input logic wr, input logic [9:0] a, input logic [15:0] d);
        int n;
        @(negedge clk1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk1);
            n++;
        end
        if (!req_ready) begin
            timeout("req_accept");
        end else begin
            if (wr) shadow[a] = d;
            else    sb.push_back('{data: shadow[a], perr: inject});
            @(posedge clk1);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk1);
            n++;
        end
        if (sb.size() != 0) timeout("rsp_wait");
        @(negedge clk1);
    endtask

    function automatic logic [4:0] strobes();
        return {mem_wr_en, mem_rd_en, mem_blk_sel, mem_addr_en, mem_dout_en};
    endfunction

    initial begin
        int   n;
        int   exp_cnt;
        logic wr;
        logic [9:0] a;

        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        rst = 1'b1; ram_init = 1'b1; inject = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        repeat (3) @(negedge clk1);
        check("reset_req_ready", {31'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_strobes", {27'h0, strobes()}, 32'h0);
        check("reset_mem_addr", {22'h0, mem_addr}, 32'h0);
        check("reset_perr_cnt", {24'h0, perr_cnt}, 32'h0);
        rst = 1'b0; ram_init = 1'b0;
        @(negedge clk1);
        check("idle_req_ready", {31'h0, req_ready}, 32'h1);

        // Write 0xA5A5 to 0x3FF: one WRITE cycle, req_ready low exactly once
        do_req(1'b1, 10'h3FF, 16'hA5A5);
        check("wr_strobes", {27'h0, strobes()}, 32'h16);
        check("wr_mem_addr", {22'h0, mem_addr}, 32'h3FF);
        check("wr_mem_din", {16'h0, mem_din}, 32'hA5A5);
        check("wr_req_ready_low", {31'h0, req_ready}, 32'h0);
        @(posedge clk1); #1;
        check("wr_req_ready_back", {31'h0, req_ready}, 32'h1);
        check("wr_strobes_off", {27'h0, strobes()}, 32'h0);
        check("wr_mem_addr_hold", {22'h0, mem_addr}, 32'h3FF);

        // Read back 0x3FF: rsp_valid three edges after accept
        do_req(1'b0, 10'h3FF, 16'h0);
        check("rd_addr_strobes", {27'h0, strobes()}, 32'h0E);
        check("rd_mem_din_hold", {16'h0, mem_din}, 32'hA5A5);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk1); #1;
            n++;
        end
        check("rd_latency_edges", n, RD_LAT + 1);
        wait_rsp();

        // Parity faults on 0x0001, counter saturates at 255
        do_req(1'b1, 10'h001, 16'h1234);
        inject = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            do_req(1'b0, 10'h001, 16'h0);
            wait_rsp();
            if (exp_cnt < 255) exp_cnt++;
            check("perr_cnt", {24'h0, perr_cnt}, exp_cnt);
        end
        inject = 1'b0;

        // Backpressure: response held, new request ignored
        rsp_ready = 1'b0;
        do_req(1'b0, 10'h3FF, 16'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk1);
            n++;
        end
        if (!rsp_valid) timeout("bp_rsp_valid");
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h005; req_wdata = 16'hBEEF;
        repeat (5) begin
            @(negedge clk1);
            check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_rsp_rdata", {16'h0, rsp_rdata}, 32'hA5A5);
            check("bp_req_ready", {31'h0, req_ready}, 32'h0);
            check("bp_no_write", {31'h0, mem_wr_en}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp();
        do_req(1'b0, 10'h005, 16'h0);
        wait_rsp();

        // Reset in the middle of a read drops it and clears the counter
        do_req(1'b0, 10'h3FF, 16'h0);
        @(negedge clk1);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk1);
            check("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
            check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            check("mid_rst_strobes", {27'h0, strobes()}, 32'h0);
            check("mid_rst_perr_cnt", {24'h0, perr_cnt}, 32'h0);
            check("mid_rst_rdata", {16'h0, rsp_rdata}, 32'h0);
        end
        sb.delete();
        rst = 1'b0;
        repeat (4) @(negedge clk1);
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);

        // Random mixed traffic against the shadow memory
        for (int i = 0; i < 10000; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(0, 1023))
                                              : 10'($urandom_range(0, 63));
            do_req(wr, a, 16'($urandom));
        end
        wait_rsp();
        check("rand_perr_cnt", {24'h0, perr_cnt}, 32'h0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
